// File: rtl/aquarium_pkg.sv
// Shared state encoding and default timing constants for the aquarium climate controller.
package aquarium_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_HEAT  = 2'd1,
    ST_COOL  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int unsigned DEF_TICK_DIV = 50000000;
  localparam int unsigned DEF_HYST     = 2;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running sample-tick divider: tick is high during the last cycle of every TICK_DIV-cycle period.
module sample_tick_gen
  import aquarium_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/aquarium_climate_ctrl.sv
// Tick-sampled heater/chiller controller with hysteresis, dwell time, humidity gate
// and a latched low-water fault that forces both pumps off.
module aquarium_climate_ctrl
  import aquarium_pkg::*;
#(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned HUM_W       = 8,
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned HYST        = DEF_HYST,
  parameter int unsigned MIN_HOLD    = 5,
  parameter int unsigned FAULT_TICKS = 3,
  parameter int unsigned HUM_GATE    = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [TEMP_W-1:0] temperature_sensor,
  input  logic [HUM_W-1:0]  humidity_sensor,
  input  logic              water_ok,
  input  logic [TEMP_W-1:0] set_temperature,
  input  logic [HUM_W-1:0]  set_humidity,
  input  logic              fault_ack,
  output logic              pump_control_hot,
  output logic              pump_control_cold,
  output logic              fault,
  output logic [1:0]        state,
  output logic              sample_tick
);

  localparam int unsigned HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int unsigned LOW_W  = $clog2(FAULT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(FAULT_TICKS);
  localparam logic [TEMP_W:0]   HYST_X   = (TEMP_W + 1)'(HYST);

  logic [TEMP_W-1:0] r_temp;
  logic [HUM_W-1:0]  r_hum;
  logic              r_water_ok;

  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [LOW_W-1:0]  r_low, w_low_nxt;
  logic              r_hot, r_cold, r_fault;
  logic              w_hot_d, w_cold_d, w_fault_d;
  logic              w_tick, w_fault_hit;

  logic [TEMP_W:0] w_t, w_s;
  logic w_heat_on, w_cool_on, w_heat_off, w_cool_off;
  logic w_heat_gate, w_cool_gate;

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_temp     <= '0;
      r_hum      <= '0;
      r_water_ok <= 1'b0;
    end else begin
      r_temp     <= temperature_sensor;
      r_hum      <= humidity_sensor;
      r_water_ok <= water_ok;
    end
  end

  // One extra bit on both sides so setpoint+HYST and T+HYST never wrap.
  assign w_t        = {1'b0, r_temp};
  assign w_s        = {1'b0, set_temperature};
  assign w_heat_on  = (w_t + HYST_X) < w_s;
  assign w_cool_on  = w_t > (w_s + HYST_X);
  assign w_heat_off = w_t >= w_s;
  assign w_cool_off = w_t <= w_s;
  assign w_heat_gate = (HUM_GATE == 0) || (r_hum > set_humidity);
  assign w_cool_gate = (HUM_GATE == 0) || (r_hum < set_humidity);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_OFF;
      r_hold  <= HOLD_MAX;
      r_low   <= '0;
      r_hot   <= 1'b0;
      r_cold  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_low   <= w_low_nxt;
      r_hot   <= w_hot_d;
      r_cold  <= w_cold_d;
      r_fault <= w_fault_d;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_low_nxt   = r_low;
    w_fault_hit = 1'b0;

    if (w_tick) begin
      if (!r_water_ok) begin
        if (r_low != LOW_MAX) w_low_nxt = r_low + LOW_W'(1);
        w_fault_hit = (w_low_nxt == LOW_MAX);
      end else begin
        w_low_nxt = '0;
      end
    end

    if (w_fault_hit) begin
      w_state_nxt = ST_FAULT;
    end else if (r_state == ST_FAULT) begin
      if (fault_ack && r_water_ok) begin
        w_state_nxt = ST_OFF;
        w_low_nxt   = '0;
        w_hold_nxt  = HOLD_MAX;
      end
    end else if (!en) begin
      w_state_nxt = ST_OFF;
      w_hold_nxt  = HOLD_MAX;
    end else if (w_tick) begin
      if (r_hold < HOLD_MAX) begin
        w_hold_nxt = r_hold + HOLD_W'(1);
      end else begin
        case (r_state)
          ST_OFF: begin
            if (w_heat_on && w_heat_gate) begin
              w_state_nxt = ST_HEAT;
              w_hold_nxt  = '0;
            end else if (w_cool_on && w_cool_gate) begin
              w_state_nxt = ST_COOL;
              w_hold_nxt  = '0;
            end
          end
          ST_HEAT: begin
            if (w_heat_off) begin
              w_state_nxt = ST_OFF;
              w_hold_nxt  = '0;
            end
          end
          ST_COOL: begin
            if (w_cool_off) begin
              w_state_nxt = ST_OFF;
              w_hold_nxt  = '0;
            end
          end
          default: w_state_nxt = r_state;
        endcase
      end
    end
  end

  always_comb begin
    w_hot_d   = (w_state_nxt == ST_HEAT);
    w_cold_d  = (w_state_nxt == ST_COOL);
    w_fault_d = (w_state_nxt == ST_FAULT);
  end

  assign pump_control_hot  = r_hot;
  assign pump_control_cold = r_cold;
  assign fault             = r_fault;
  assign state             = r_state;
  assign sample_tick       = w_tick;

endmodule

// File: tb/tb_aquarium_climate_ctrl.sv
// Bench for aquarium_climate_ctrl: tick-by-tick vector table scored through a queue,
// plus direct sequences for reset, fault acknowledge and enable drop.
module tb_aquarium_climate_ctrl;

  logic       clk = 1'b0;
  logic       clr, en, water_ok, fault_ack;
  logic [7:0] temperature_sensor, humidity_sensor, set_temperature, set_humidity;
  logic       pump_control_hot, pump_control_cold, fault, sample_tick;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  aquarium_climate_ctrl #(
    .TEMP_W(8), .HUM_W(8), .TICK_DIV(4), .HYST(2),
    .MIN_HOLD(2), .FAULT_TICKS(3), .HUM_GATE(1)
  ) dut (
    .clk                (clk),
    .clr                (clr),
    .en                 (en),
    .temperature_sensor (temperature_sensor),
    .humidity_sensor    (humidity_sensor),
    .water_ok           (water_ok),
    .set_temperature    (set_temperature),
    .set_humidity       (set_humidity),
    .fault_ack          (fault_ack),
    .pump_control_hot   (pump_control_hot),
    .pump_control_cold  (pump_control_cold),
    .fault              (fault),
    .state              (state),
    .sample_tick        (sample_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] t, h, s, sh;
    logic       w;
    logic [1:0] st;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[$];

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic check_outs(input string name, input logic [1:0] st);
    check1({name, ".state"}, {30'd0, state}, {30'd0, st});
    check1({name, ".hot"},   {31'd0, pump_control_hot},  {31'd0, st == 2'd1});
    check1({name, ".cold"},  {31'd0, pump_control_cold}, {31'd0, st == 2'd2});
    check1({name, ".fault"}, {31'd0, fault},             {31'd0, st == 2'd3});
  endtask

  function automatic void add(input string name, input int t, input int h, input int s,
                              input int sh, input bit w, input int st);
    vec_t v;
    v.name = name;
    v.t = 8'(t); v.h = 8'(h); v.s = 8'(s); v.sh = 8'(sh);
    v.w = w; v.st = 2'(st);
    vt.push_back(v);
  endfunction

  // Scoreboard: after every tick edge, compare against the oldest pending expectation.
  logic tick_armed = 1'b0;
  always @(negedge clk) tick_armed <= sample_tick;

  always @(posedge clk) begin : mon
    exp_t e;
    if (tick_armed === 1'b1) begin
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_outs(e.name, e.st);
      end
    end
  end

  // Leaves the caller 2 time units after the next tick edge.
  task automatic sync_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sample_tick !== 1'b1 && n < 20);
    if (sample_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL sync_tick: sample_tick=%b after %0d cycles, required 1", sample_tick, n);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic push(input string name, input int st);
    exp_t e;
    e.name = name;
    e.st   = 2'(st);
    exp_q.push_back(e);
  endtask

  initial begin
    clr = 1'b1; en = 1'b1; water_ok = 1'b1; fault_ack = 1'b0;
    temperature_sensor = 8'd97; humidity_sensor = 8'd60;
    set_temperature = 8'd100; set_humidity = 8'd50;

    // Reset state and first-tick latency.
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 2'd0);
    check1("reset.sample_tick", {31'd0, sample_tick}, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    push("first_tick_heat", 1);
    repeat (3) @(posedge clk);
    #1;
    check1("pre_first_tick.state", {30'd0, state}, 32'd0);
    check1("pre_first_tick.sample_tick", {31'd0, sample_tick}, 32'd1);
    @(posedge clk);
    #2;

    add("heat_hold_T99",       99, 60, 100, 50, 1, 1);
    add("heat_dwell_T100",    100, 60, 100, 50, 1, 1);
    add("heat_exit_3rd_tick", 100, 60, 100, 50, 1, 0);
    add("off_dwell1",          98, 60, 100, 50, 1, 0);
    add("off_dwell2",          98, 60, 100, 50, 1, 0);
    add("hyst_edge_off",       98, 60, 100, 50, 1, 0);
    add("gate_blocks_cool",   103, 60, 100, 50, 1, 0);
    add("cool_entry",         103, 40, 100, 50, 1, 2);
    add("cool_dwell1",        103, 40, 100, 50, 1, 2);
    add("cool_dwell2",        100, 40, 100, 50, 1, 2);
    add("cool_exit",          100, 40, 100, 50, 1, 0);
    add("off_dwell1b",         97, 60, 100, 50, 1, 0);
    add("off_dwell2b",         97, 60, 100, 50, 1, 0);
    add("heat_entry",          97, 60, 100, 50, 1, 1);
    add("heat_dwell1",         97, 60, 100, 50, 1, 1);
    add("heat_dwell2",         97, 60, 100, 50, 1, 1);
    add("no_swap_off",        120, 40, 100, 50, 1, 0);
    add("swap_dwell1",        120, 40, 100, 50, 1, 0);
    add("swap_dwell2",        120, 40, 100, 50, 1, 0);
    add("cool_after_off",     120, 40, 100, 50, 1, 2);
    add("max_dwell1",         255, 40, 255, 50, 1, 2);
    add("max_dwell2",         255, 40, 255, 50, 1, 2);
    add("max_cool_exit",      255, 40, 255, 50, 1, 0);
    add("max_off1",           255, 40, 255, 50, 1, 0);
    add("max_off2",           255, 40, 255, 50, 1, 0);
    add("max_no_cool_wrap",   255, 40, 255, 50, 1, 0);
    add("zero_no_heat_wrap",    0, 60,   0, 50, 1, 0);
    add("cool_hyst_edge_253", 255, 40, 253, 50, 1, 0);
    add("cool_hyst_252",      255, 40, 252, 50, 1, 2);
    add("c_dwell1",           252, 40, 252, 50, 1, 2);
    add("c_dwell2",           252, 40, 252, 50, 1, 2);
    add("c_exit",             252, 40, 252, 50, 1, 0);
    add("o_dwell1",            97, 60, 100, 50, 1, 0);
    add("o_dwell2",            97, 60, 100, 50, 1, 0);
    add("heat_again",          97, 60, 100, 50, 1, 1);
    add("low_water1",          97, 60, 100, 50, 0, 1);
    add("low_water2",          97, 60, 100, 50, 0, 1);
    add("fault_entry",         97, 60, 100, 50, 0, 3);

    for (int i = 0; i < vt.size(); i++) begin
      temperature_sensor = vt[i].t;
      humidity_sensor    = vt[i].h;
      set_temperature    = vt[i].s;
      set_humidity       = vt[i].sh;
      water_ok           = vt[i].w;
      push(vt[i].name, int'(vt[i].st));
      sync_tick();
    end

    // Acknowledge is ignored while water is still low.
    fault_ack = 1'b1;
    @(posedge clk);
    #1;
    check_outs("ack_low_water", 2'd3);
    fault_ack = 1'b0;
    water_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outs("fault_held_no_ack", 2'd3);
    fault_ack = 1'b1;
    @(posedge clk);
    #1;
    check_outs("ack_release", 2'd0);
    #1;
    fault_ack = 1'b0;

    temperature_sensor = 8'd103; humidity_sensor = 8'd40;
    set_temperature = 8'd100; set_humidity = 8'd50;
    push("cool_after_ack", 2);
    sync_tick();

    // Enable drop acts on the very next edge, not at a tick.
    en = 1'b0;
    @(posedge clk);
    #1;
    check_outs("en_low_off", 2'd0);
    #1;
    push("en_low_stays_off", 0);
    sync_tick();

    en = 1'b1; water_ok = 1'b0;
    temperature_sensor = 8'd97; humidity_sensor = 8'd60;
    push("refault_heat1", 1);
    sync_tick();
    push("refault_heat2", 1);
    sync_tick();
    push("refault_fault", 3);
    sync_tick();

    // Reset in the middle of FAULT.
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_outs("reset_mid_fault", 2'd0);
    check1("reset_mid_fault.sample_tick", {31'd0, sample_tick}, 32'd0);
    water_ok = 1'b1;
    temperature_sensor = 8'd103; humidity_sensor = 8'd40;
    @(negedge clk);
    clr = 1'b0;
    push("post_reset_first_tick_cool", 2);
    repeat (3) @(posedge clk);
    #1;
    check1("post_reset_pre_tick.state", {30'd0, state}, 32'd0);
    check1("post_reset_pre_tick.sample_tick", {31'd0, sample_tick}, 32'd1);
    @(posedge clk);
    #2;

    check1("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aquarium_climate_ctrl.md
Name: aquarium_climate_ctrl

Overview:
Parametrised, tick-sampled heater/chiller controller for the aquarium tank, the next generation of the fixed 2-bit controller.
- Widths are configurable; temperature control uses hysteresis.
- Enforces minimum on/off dwell time and an optional humidity gate.
- Latches a low-water fault that forces both pumps off.
- Sits between the sensor inputs and the hot/cold pump drivers.

Parameters:
- TEMP_W, 8, width of temperature sensor and setpoint.
- HUM_W, 8, width of humidity sensor and setpoint.
- TICK_DIV, 50000000, clk cycles per sample tick (>=2).
- HYST, 2, temperature hysteresis band in LSBs (0..2^TEMP_W-1).
- MIN_HOLD, 5, minimum ticks spent in OFF/HEAT/COOL before leaving (0 = no dwell).
- FAULT_TICKS, 3, consecutive low-water ticks that latch FAULT (>=1).
- HUM_GATE, 1, 1 = humidity condition required to enter HEAT/COOL; 0 = ignored.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- clr  input  1  synchronous active-high reset.
- en  input  1  control enable; low forces OFF.
- temperature_sensor  input  TEMP_W  raw temperature.
- humidity_sensor  input  HUM_W  raw humidity.
- water_ok  input  1  1 = water level acceptable.
- set_temperature  input  TEMP_W  temperature setpoint.
- set_humidity  input  HUM_W  humidity setpoint.
- fault_ack  input  1  clears latched FAULT when water_ok=1.
- pump_control_hot  output  1  heater pump drive.
- pump_control_cold  output  1  chiller pump drive.
- fault  output  1  low-water fault latched.
- state  output  2  current FSM state.
- sample_tick  output  1  one-cycle pulse per sample (debug/visibility).

Behaviour:
- Reset (clr=1 at a clk edge) sets:
  - all outputs to 0 and state to OFF;
  - tick_cnt, low_cnt and the sensor registers to 0;
  - hold_cnt to MIN_HOLD, so the first tick may act.
- Sensor inputs and water_ok are registered every cycle (1 flop). Decisions use the registered values.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - sample_tick=1 in the cycle where tick_cnt==TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after reset release.
  - tick_cnt is unaffected by en, fault or fault_ack.
- State and outputs change only on the edge ending a sample_tick cycle. Exceptions: en low and fault_ack act on any edge (see below).
- States: OFF=0, HEAT=1, COOL=2, FAULT=3. Outputs are registered and updated on the same edge as state:
  - HEAT gives hot=1, cold=0.
  - COOL gives cold=1, hot=0.
  - OFF and FAULT give both 0.
  - fault=1 iff state==FAULT.
- Arithmetic: comparisons are done in TEMP_W+1 bits (zero-extended), so there is no overflow or wrap.
  - heat_on = T+HYST < S.
  - cool_on = T > S+HYST.
  - heat_off = T >= S.
  - cool_off = T <= S.
- Humidity gate (HUM_GATE=1): HEAT entry also needs H > SH; COOL entry also needs H < SH. The exit conditions ignore humidity.
- low_cnt: at each tick, increment (saturating at FAULT_TICKS) if water_ok=0, else clear to 0.
- Transition priority at a tick, highest first:
  1. FAULT entry: low_cnt reaches FAULT_TICKS on this tick (any state; ignores dwell and en).
  2. FAULT is held until fault_ack=1 with registered water_ok=1 on any edge. This goes to OFF, clears low_cnt and sets hold_cnt=MIN_HOLD. fault_ack is ignored otherwise.
  3. en=0: state goes to OFF on any edge, hold_cnt is set to MIN_HOLD, and FAULT is not left.
  4. Dwell: if hold_cnt < MIN_HOLD, hold_cnt increments and state is held.
  5. OFF goes to HEAT if heat_on (and gate), else to COOL if cool_on (and gate).
  6. HEAT goes to OFF if heat_off; COOL goes to OFF if cool_off.
  7. There is never a direct HEAT<->COOL move; the path always passes through OFF.
- Every entry into OFF/HEAT/COOL via a tick sets hold_cnt=0.
- hold_cnt width is clog2(MIN_HOLD+1), minimum 1 bit.
- Reset mid-operation: clr wins over everything on that edge.
- Simultaneous fault_ack and a fault tick: the fault tick wins and FAULT remains.
- Latency: a sensor change stable at least 2 cycles before a tick edge is acted on at that tick edge, and the pump output changes on that same edge.

Decomposition:
- Shared package aquarium_pkg holds:
  - the state encoding constants (OFF, HEAT, COOL, FAULT, 2-bit);
  - the default constants for TICK_DIV and HYST.
- One sub-module, sample_tick_gen (parameter TICK_DIV; ports clk, clr, tick), is instantiated for the tick counter.
- The FSM, dwell counter, fault counter and comparators stay in the top module.

Test Plan:
All scenarios use TICK_DIV=4, HYST=2, MIN_HOLD=2, FAULT_TICKS=3, HUM_GATE=1, en=1 and water_ok=1 unless stated.
1. Heat cycle: S=100, SH=50, T=97, H=60 -> hot=1 at the first tick (cycle 4). Then T=99 keeps hot=1. Then T=100 gives hot=0, but only at the 3rd tick after entry.
2. Hysteresis and gate:
   - S=100, T=98 (T+HYST == S) -> stays OFF.
   - T=103, H=40 -> cold=1.
   - T=103, H=60 -> stays OFF because of the gate.
3. No direct swap: in HEAT after dwell, jump T to 120 -> OFF at the next tick. COOL is only entered 2 further ticks later (dwell from OFF).
4. Fault: in HEAT, water_ok=0 for 3 ticks -> state=3, fault=1, hot=0 at the 3rd tick. fault_ack with water_ok=0 -> no change. Restore water_ok, then fault_ack -> OFF, fault=0.
5. en and reset:
   - en=0 while in COOL -> cold=0 and state=OFF on the next edge, without waiting for a tick.
   - clr=1 mid-FAULT -> all outputs 0, state=0, and the first tick 4 cycles after release.
6. Edge widths: TEMP_W=8, S=255, T=255, HYST=2 -> no COOL (no wrap). S=0, T=0 -> no HEAT.
